// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy state and its
// two-bit encoding.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // The state encoding doubles as the number of held entries.
    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop with synchronous active-high reset to a fixed value.
module dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid register so in_ready never
// depends combinationally on out_ready; stall freezes, flush empties.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    pipe_state_e      state_q, state_d;
    logic [OCC_W-1:0] occ_q;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;
    logic             accept, drain;

    assign in_ready  = (state_q != ST_TWO) & ~stall & ~flush & ~rst;
    assign out_valid = (state_q != ST_EMPTY) & ~stall & ~rst;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        skid_en = 1'b1;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (drain) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_of(state_d);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        dff #(.WIDTH(1), .RESET_VAL(RESET_VAL[gi])) u_main (
            .clk (clk),
            .rst (rst),
            .en  (main_en),
            .d   (main_d[gi]),
            .q   (main_q[gi])
        );
        dff #(.WIDTH(1), .RESET_VAL(RESET_VAL[gi])) u_skid (
            .clk (clk),
            .rst (rst),
            .en  (skid_en),
            .d   (in_data[gi]),
            .q   (skid_q[gi])
        );
    end

    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule
